// File: rtl/j2_core_sequencer.sv
// j2 stack CPU control sequencer: fetch, bus phases around the ALU, and
// single-cycle commit of pc and stack pointers.
module j2_core_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reboot,
    output logic [12:0]      mem_addr,
    output logic             mem_read_req,
    output logic             mem_write_req,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] io_addr,
    output logic             io_read_req,
    output logic             io_write_req,
    output logic [WIDTH-1:0] io_write_data,
    input  logic [WIDTH-1:0] io_read_data,
    input  logic             io_ready,
    output logic [15:0]      instruction,
    output logic [12:0]      program_counter,
    output logic [DEPTH-1:0] data_stack_read_position,
    output logic [DEPTH-1:0] return_stack_read_position,
    input  logic [WIDTH-1:0] data_stack_current_top,
    input  logic [WIDTH-1:0] data_stack_current_next_top,
    output logic [WIDTH-1:0] memory_data_latched,
    output logic [WIDTH-1:0] io_data_latched,
    input  logic [12:0]      alu_pc_next,
    input  logic [DEPTH-1:0] alu_ds_next_pos,
    input  logic             alu_ds_write,
    input  logic [DEPTH-1:0] alu_rs_next_pos,
    input  logic             alu_rs_write,
    output logic             data_stack_we,
    output logic             return_stack_we,
    output logic             commit
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_IOREAD,
        S_STORE,
        S_IOWRITE,
        S_EXECUTE
    } state_t;

    state_t           state_q, state_d;
    logic             boot_q, boot_d;
    logic [12:0]      pc_q, pc_d;
    logic [15:0]      instr_q, instr_d;
    logic [DEPTH-1:0] dsp_q, dsp_d;
    logic [DEPTH-1:0] rsp_q, rsp_d;
    logic [WIDTH-1:0] mem_lat_q, mem_lat_d;
    logic [WIDTH-1:0] io_lat_q, io_lat_d;

    logic             is_alu;
    logic [3:0]       op_nib;
    logic [2:0]       func;
    logic             bus_live;
    state_t           after_read;

    assign is_alu   = (instr_q[15:13] == 3'b011);
    assign op_nib   = instr_q[11:8];
    assign func     = instr_q[6:4];
    // The cycle right after a reboot edge issues no request at all.
    assign bus_live = !boot_q;

    always_comb begin
        after_read = S_EXECUTE;
        if (func == 3'd3) begin
            after_read = S_STORE;
        end else if (func == 3'd4) begin
            after_read = S_IOWRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (reboot) begin
            state_q   <= S_FETCH;
            boot_q    <= 1'b1;
            pc_q      <= '0;
            instr_q   <= '0;
            dsp_q     <= '0;
            rsp_q     <= '0;
            mem_lat_q <= '0;
            io_lat_q  <= '0;
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            dsp_q     <= dsp_d;
            rsp_q     <= rsp_d;
            mem_lat_q <= mem_lat_d;
            io_lat_q  <= io_lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (bus_live && mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu && op_nib == 4'hC) begin
                    state_d = S_LOAD;
                end else if (is_alu && op_nib == 4'hD) begin
                    state_d = S_IOREAD;
                end else if (is_alu && func == 3'd3) begin
                    state_d = S_STORE;
                end else if (is_alu && func == 3'd4) begin
                    state_d = S_IOWRITE;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_LOAD: begin
                if (bus_live && mem_ready) state_d = after_read;
            end
            S_IOREAD: begin
                if (bus_live && io_ready) state_d = after_read;
            end
            S_STORE: begin
                if (bus_live && mem_ready) begin
                    state_d = (func == 3'd4) ? S_IOWRITE : S_EXECUTE;
                end
            end
            S_IOWRITE: begin
                if (bus_live && io_ready) state_d = S_EXECUTE;
            end
            S_EXECUTE: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        boot_d    = 1'b0;
        pc_d      = pc_q;
        instr_d   = instr_q;
        dsp_d     = dsp_q;
        rsp_d     = rsp_q;
        mem_lat_d = mem_lat_q;
        io_lat_d  = io_lat_q;
        if (bus_live && state_q == S_FETCH && mem_ready) begin
            instr_d = mem_read_data;
        end
        if (bus_live && state_q == S_LOAD && mem_ready) begin
            mem_lat_d = mem_read_data;
        end
        if (bus_live && state_q == S_IOREAD && io_ready) begin
            io_lat_d = io_read_data;
        end
        if (state_q == S_EXECUTE) begin
            pc_d  = alu_pc_next;
            dsp_d = alu_ds_next_pos;
            rsp_d = alu_rs_next_pos;
        end
    end

    always_comb begin
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        io_read_req   = 1'b0;
        io_write_req  = 1'b0;
        commit        = 1'b0;
        mem_addr      = pc_q;
        io_addr       = '0;
        unique case (state_q)
            S_FETCH: begin
                mem_read_req = bus_live;
            end
            S_LOAD: begin
                mem_read_req = bus_live;
                mem_addr     = data_stack_current_top[13:1];
            end
            S_STORE: begin
                mem_write_req = bus_live;
                mem_addr      = data_stack_current_top[13:1];
            end
            S_IOREAD: begin
                io_read_req = bus_live;
                io_addr     = data_stack_current_top;
            end
            S_IOWRITE: begin
                io_write_req = bus_live;
                io_addr      = data_stack_current_top;
            end
            S_EXECUTE: commit = 1'b1;
            default:   commit = 1'b0;
        endcase
    end

    assign data_stack_we              = alu_ds_write & commit;
    assign return_stack_we            = alu_rs_write & commit;
    assign mem_write_data             = data_stack_current_next_top;
    assign io_write_data              = data_stack_current_next_top;
    assign instruction                = instr_q;
    assign program_counter            = pc_q;
    assign data_stack_read_position   = dsp_q;
    assign return_stack_read_position = rsp_q;
    assign memory_data_latched        = mem_lat_q;
    assign io_data_latched            = io_lat_q;

endmodule

// File: tb/tb_j2_core_sequencer.sv
// Bench for j2_core_sequencer: directed scenarios plus random bus timing,
// all checked each cycle against a phase-schedule model.
module tb_j2_core_sequencer;

    logic        clk;
    logic        reboot;
    logic [12:0] mem_addr;
    logic        mem_read_req, mem_write_req;
    logic [15:0] mem_write_data, mem_read_data;
    logic        mem_ready;
    logic [15:0] io_addr;
    logic        io_read_req, io_write_req;
    logic [15:0] io_write_data, io_read_data;
    logic        io_ready;
    logic [15:0] instruction;
    logic [12:0] program_counter;
    logic [3:0]  dsp, rsp;
    logic [15:0] t_in, n_in;
    logic [15:0] mem_lat, io_lat;
    logic [12:0] alu_pc_next;
    logic [3:0]  alu_ds_next_pos, alu_rs_next_pos;
    logic        alu_ds_write, alu_rs_write;
    logic        data_stack_we, return_stack_we, commit;

    int checks = 0;
    int errors = 0;

    j2_core_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk),
        .reboot(reboot),
        .mem_addr(mem_addr),
        .mem_read_req(mem_read_req),
        .mem_write_req(mem_write_req),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .mem_ready(mem_ready),
        .io_addr(io_addr),
        .io_read_req(io_read_req),
        .io_write_req(io_write_req),
        .io_write_data(io_write_data),
        .io_read_data(io_read_data),
        .io_ready(io_ready),
        .instruction(instruction),
        .program_counter(program_counter),
        .data_stack_read_position(dsp),
        .return_stack_read_position(rsp),
        .data_stack_current_top(t_in),
        .data_stack_current_next_top(n_in),
        .memory_data_latched(mem_lat),
        .io_data_latched(io_lat),
        .alu_pc_next(alu_pc_next),
        .alu_ds_next_pos(alu_ds_next_pos),
        .alu_ds_write(alu_ds_write),
        .alu_rs_next_pos(alu_rs_next_pos),
        .alu_rs_write(alu_rs_write),
        .data_stack_we(data_stack_we),
        .return_stack_we(return_stack_we),
        .commit(commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the remaining bus phases of the current instruction as a list.
    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_LOAD   = 2;
    localparam int P_IORD   = 3;
    localparam int P_STORE  = 4;
    localparam int P_IOWR   = 5;
    localparam int P_EXEC   = 6;

    int          ph[$];
    bit          m_valid = 0;
    bit          m_boot;
    logic [12:0] m_pc;
    logic [15:0] m_ir, m_mlat, m_iolat;
    logic [3:0]  m_dsp, m_rsp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic schedule(input logic [15:0] ir);
        bit alu;
        alu = (ir[15:13] == 3'b011);
        ph.delete();
        ph.push_back(P_DECODE);
        if (alu && ir[11:8] == 4'hC) ph.push_back(P_LOAD);
        else if (alu && ir[11:8] == 4'hD) ph.push_back(P_IORD);
        if (alu && ir[6:4] == 3'd3) ph.push_back(P_STORE);
        if (alu && ir[6:4] == 3'd4) ph.push_back(P_IOWR);
        ph.push_back(P_EXEC);
    endtask

    task automatic compare();
        int cur;
        bit memph;
        if (!m_valid) return;
        cur = m_boot ? -1 : ph[0];
        memph = (cur == P_FETCH || cur == P_LOAD || cur == P_STORE);
        chk("mem_read_req", mem_read_req, cur == P_FETCH || cur == P_LOAD);
        chk("mem_write_req", mem_write_req, cur == P_STORE);
        chk("io_read_req", io_read_req, cur == P_IORD);
        chk("io_write_req", io_write_req, cur == P_IOWR);
        chk("commit", commit, cur == P_EXEC);
        chk("ds_we", data_stack_we, alu_ds_write && cur == P_EXEC);
        chk("rs_we", return_stack_we, alu_rs_write && cur == P_EXEC);
        if (memph) begin
            chk("mem_addr", mem_addr,
                (cur == P_FETCH) ? m_pc : t_in[13:1]);
        end
        chk("io_addr", io_addr,
            (cur == P_IORD || cur == P_IOWR) ? t_in : 16'h0);
        chk("mem_wdata", mem_write_data, n_in);
        chk("io_wdata", io_write_data, n_in);
        chk("instruction", instruction, m_ir);
        chk("pc", program_counter, m_pc);
        chk("dsp", dsp, m_dsp);
        chk("rsp", rsp, m_rsp);
        chk("mem_lat", mem_lat, m_mlat);
        chk("io_lat", io_lat, m_iolat);
    endtask

    task automatic model_edge();
        if (reboot) begin
            m_valid = 1;
            m_boot  = 1;
            m_pc    = '0;
            m_ir    = '0;
            m_dsp   = '0;
            m_rsp   = '0;
            m_mlat  = '0;
            m_iolat = '0;
            ph.delete();
            ph.push_back(P_FETCH);
            return;
        end
        if (!m_valid) return;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        case (ph[0])
            P_FETCH: if (mem_ready) begin
                m_ir = mem_read_data;
                schedule(m_ir);
            end
            P_DECODE: ph.delete(0);
            P_LOAD: if (mem_ready) begin
                m_mlat = mem_read_data;
                ph.delete(0);
            end
            P_IORD: if (io_ready) begin
                m_iolat = io_read_data;
                ph.delete(0);
            end
            P_STORE: if (mem_ready) ph.delete(0);
            P_IOWR: if (io_ready) ph.delete(0);
            default: begin
                m_pc  = alu_pc_next;
                m_dsp = alu_ds_next_pos;
                m_rsp = alu_rs_next_pos;
                ph.delete();
                ph.push_back(P_FETCH);
            end
        endcase
    endtask

    task automatic tick();
        #1;
        compare();
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_instr();
        logic [2:0] f;
        f = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
        if ($urandom_range(0, 1) != 0) f = 3'($urandom);
        case ($urandom_range(0, 5))
            0:       return 16'h6C00 | {9'd0, f, 4'($urandom)};
            1:       return 16'h6D00 | {9'd0, f, 4'($urandom)};
            2:       return {3'b011, 6'($urandom), f, 4'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    int ncommit;

    initial begin
        reboot          = 1'b1;
        mem_ready       = 1'b0;
        io_ready        = 1'b0;
        mem_read_data   = '0;
        io_read_data    = '0;
        t_in            = '0;
        n_in            = '0;
        alu_pc_next     = '0;
        alu_ds_next_pos = '0;
        alu_rs_next_pos = '0;
        alu_ds_write    = 1'b0;
        alu_rs_write    = 1'b0;
        repeat (3) tick();

        // boot and a literal instruction
        reboot = 1'b0;
        mem_ready = 1'b1;
        mem_read_data = 16'h8005;
        alu_ds_write = 1'b1;
        alu_pc_next = 13'h0001;
        alu_ds_next_pos = 4'h1;
        #1;
        chk("lit boot no req", mem_read_req, 1'b0);
        chk("lit boot pc", program_counter, 13'h0);
        chk("lit boot ir", instruction, 16'h0);
        tick();
        #1;
        chk("lit fetch req", mem_read_req, 1'b1);
        chk("lit fetch addr", mem_addr, 13'h0);
        tick();
        #1;
        chk("lit decode ir", instruction, 16'h8005);
        chk("lit decode commit", commit, 1'b0);
        tick();
        #1;
        chk("lit exec commit", commit, 1'b1);
        chk("lit exec ds_we", data_stack_we, 1'b1);
        tick();
        #1;
        chk("lit pc next", program_counter, 13'h0001);
        chk("lit dsp next", dsp, 4'h1);

        // fetch with 4 wait cycles
        alu_ds_write = 1'b0;
        alu_pc_next = 13'h0002;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0;
            mem_read_data = 16'($urandom);
            #1;
            chk("lit wait req", mem_read_req, 1'b1);
            chk("lit wait addr", mem_addr, 13'h0001);
            chk("lit wait ir", instruction, 16'h8005);
            tick();
        end
        mem_ready = 1'b1;
        mem_read_data = 16'h6C00;
        tick();
        #1;
        chk("lit load ir", instruction, 16'h6C00);
        tick();

        // load phase
        t_in = 16'h0040;
        mem_read_data = 16'hBEEF;
        #1;
        chk("lit load req", mem_read_req, 1'b1);
        chk("lit load addr", mem_addr, 13'h020);
        tick();
        #1;
        chk("lit load lat", mem_lat, 16'hBEEF);
        chk("lit load exec", commit, 1'b1);
        tick();

        // store phase
        mem_read_data = 16'h6030;
        tick();
        tick();
        t_in = 16'h0010;
        n_in = 16'h1234;
        #1;
        chk("lit store wreq", mem_write_req, 1'b1);
        chk("lit store rreq", mem_read_req, 1'b0);
        chk("lit store addr", mem_addr, 13'h008);
        chk("lit store data", mem_write_data, 16'h1234);
        tick();
        #1;
        chk("lit store exec", commit, 1'b1);
        tick();

        // io read then io write, one commit
        mem_read_data = 16'h6D40;
        tick();
        t_in = 16'h0077;
        io_ready = 1'b1;
        io_read_data = 16'h5A5A;
        ncommit = 0;
        #1;
        ncommit += int'(commit);
        tick();
        #1;
        chk("lit iord req", io_read_req, 1'b1);
        chk("lit iord addr", io_addr, 16'h0077);
        ncommit += int'(commit);
        tick();
        #1;
        chk("lit iowr req", io_write_req, 1'b1);
        chk("lit iowr addr", io_addr, 16'h0077);
        chk("lit io lat", io_lat, 16'h5A5A);
        ncommit += int'(commit);
        tick();
        #1;
        ncommit += int'(commit);
        tick();
        chk("lit io commits", ncommit, 1);
        io_ready = 1'b0;

        // reboot during a load wait
        mem_read_data = 16'h6C00;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        reboot = 1'b1;
        mem_ready = 1'b1;
        mem_read_data = 16'hDEAD;
        tick();
        reboot = 1'b0;
        #1;
        chk("lit rb rreq", mem_read_req, 1'b0);
        chk("lit rb wreq", mem_write_req, 1'b0);
        chk("lit rb io", {io_read_req, io_write_req}, 2'b00);
        chk("lit rb pc", program_counter, 13'h0);
        chk("lit rb lat", mem_lat, 16'h0);
        tick();
        #1;
        chk("lit rb fetch", mem_read_req, 1'b1);
        chk("lit rb addr", mem_addr, 13'h0);
        tick();

        // random bus timing and instruction mix
        for (int c = 0; c < 4000; c++) begin
            reboot          = ($urandom_range(0, 63) == 0);
            mem_ready       = ($urandom_range(0, 1) != 0);
            io_ready        = ($urandom_range(0, 1) != 0);
            mem_read_data   = pick_instr();
            io_read_data    = 16'($urandom);
            t_in            = 16'($urandom);
            n_in            = 16'($urandom);
            alu_pc_next     = 13'($urandom);
            alu_ds_next_pos = 4'($urandom);
            alu_rs_next_pos = 4'($urandom);
            alu_ds_write    = 1'($urandom);
            alu_rs_write    = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
